// File: rtl/sm_dbg_ctrl.sv
// Debug controller: run/halt/single-step control of a CPU clock enable plus a 32-word register dump stream.
// Optional PC breakpoint is built only when SM_DBG_BREAKPOINT_EN is defined.
module sm_dbg_ctrl #(
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    output logic        cpu_en,
    input  logic [31:0] pc,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic        halted,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        bp_hit
);
    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    typedef enum logic [2:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_DUMP_RD,
        S_DUMP_OUT
    } state_t;

    state_t      state_reg;
    logic [4:0]  index_reg;
    logic        dump_valid_reg;
    logic [4:0]  dump_addr_reg;
    logic [31:0] dump_data_reg;
    logic        cmd_fire;
    logic        bp_fire;

`ifdef SM_DBG_BREAKPOINT_EN
    logic skip_reg;
    logic bp_hit_reg;

    // Skip lets a resumed RUN execute the instruction sitting at the breakpoint.
    assign bp_fire = (state_reg == S_RUN) && bp_en && (pc == bp_addr) && !skip_reg;
    assign bp_hit  = bp_hit_reg;
`else
    logic unused_bp;

    assign bp_fire   = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

    assign cmd_ready  = (state_reg == S_HALT) || (state_reg == S_RUN);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cpu_en     = (state_reg == S_STEP) || ((state_reg == S_RUN) && !bp_fire);
    assign halted     = (state_reg == S_HALT);
    assign regAddr    = (state_reg == S_DUMP_RD) ? index_reg : 5'd0;
    assign dump_valid = dump_valid_reg;
    assign dump_addr  = dump_addr_reg;
    assign dump_data  = dump_data_reg;
    assign dump_last  = dump_valid_reg && (dump_addr_reg == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN_ON_RESET ? S_RUN : S_HALT;
            index_reg      <= 5'd0;
            dump_valid_reg <= 1'b0;
            dump_addr_reg  <= 5'd0;
            dump_data_reg  <= 32'd0;
`ifdef SM_DBG_BREAKPOINT_EN
            skip_reg       <= 1'b0;
            bp_hit_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_HALT: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_RUN: begin
                                state_reg  <= S_RUN;
`ifdef SM_DBG_BREAKPOINT_EN
                                skip_reg   <= 1'b1;
                                bp_hit_reg <= 1'b0;
`endif
                            end
                            OP_STEP: begin
                                state_reg  <= S_STEP;
`ifdef SM_DBG_BREAKPOINT_EN
                                bp_hit_reg <= 1'b0;
`endif
                            end
                            OP_DUMP: begin
                                state_reg <= S_DUMP_RD;
                                index_reg <= 5'd0;
                            end
                            default: state_reg <= S_HALT;
                        endcase
                    end
                end
                S_RUN: begin
`ifdef SM_DBG_BREAKPOINT_EN
                    skip_reg <= 1'b0;
`endif
                    if (bp_fire) begin
                        state_reg  <= S_HALT;
`ifdef SM_DBG_BREAKPOINT_EN
                        bp_hit_reg <= 1'b1;
`endif
                    end else if (cmd_fire && (cmd_op == OP_HALT)) begin
                        state_reg <= S_HALT;
                    end
                end
                S_STEP: state_reg <= S_HALT;
                S_DUMP_RD: begin
                    dump_data_reg  <= regData;
                    dump_addr_reg  <= index_reg;
                    dump_valid_reg <= 1'b1;
                    state_reg      <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (dump_ready) begin
                        dump_valid_reg <= 1'b0;
                        if (index_reg == 5'd31) begin
                            state_reg <= S_HALT;
                        end else begin
                            index_reg <= index_reg + 5'd1;
                            state_reg <= S_DUMP_RD;
                        end
                    end
                end
                default: state_reg <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Directed bench for sm_dbg_ctrl with a small CPU model and a dump-word scoreboard.
// Breakpoint checks follow SM_DBG_BREAKPOINT_EN.
module tb_sm_dbg_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic        cpu_en;
    logic [31:0] pc;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        halted;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic        bp_hit;

    logic        pc_load = 1'b1;
    logic [31:0] pc_load_val = 32'd0;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } word_t;
    word_t sb[$];

    sm_dbg_ctrl #(.RUN_ON_RESET(1'b0)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cpu_en(cpu_en), .pc(pc), .regAddr(regAddr), .regData(regData),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last), .halted(halted),
        .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    // CPU model: one instruction per enabled cycle, register file reads 0xA0+addr, addr 0 returns pc.
    always_ff @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (cpu_en) pc <= pc + 32'd1;
    end
    assign regData = (regAddr == 5'd0) ? pc : 32'hA0 + 32'(regAddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        tick;
        pc_load = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          cyc;
        int          words;
        int          extra;
        bit          held;
        bit          found;
        bit          cpu_seen;
        logic [31:0] held_data;
        logic [4:0]  held_addr;
        word_t       e;

        // Reset state
        tick; tick;
        rst = 1'b0;
        pc_load = 1'b0;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_regaddr", 32'(regAddr), 32'd0);
        chk("rst_dump_last", 32'(dump_last), 32'd0);
        $display("[TB] reset checked");

        // Single step
        send(2'b10);
        chk("step_cpu_en", 32'(cpu_en), 32'd1);
        chk("step_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("step_halted", 32'(halted), 32'd0);
        tick;
        chk("step_back_halted", 32'(halted), 32'd1);
        chk("step_cpu_en_off", 32'(cpu_en), 32'd0);
        chk("step_pc", pc, 32'd1);
        $display("[TB] step pc=%0h", pc);

        // RUN for 10 cycles, with an ignored DUMP in the middle
        cnt = 0;
        cpu_seen = 1'b0;
        send(2'b00);
        for (int i = 0; i < 10; i++) begin
            if (cpu_en) cnt++;
            if (dump_valid) cpu_seen = 1'b1;
            cmd_valid = (i == 3) || (i == 9);
            cmd_op    = (i == 9) ? 2'b01 : 2'b11;
            if (i == 5) chk("run_not_halted", 32'(halted), 32'd0);
            tick;
        end
        cmd_valid = 1'b0;
        chk("run_cpu_en_cycles", 32'(cnt), 32'd10);
        chk("run_then_halted", 32'(halted), 32'd1);
        chk("run_pc", pc, 32'd11);
        chk("run_dump_ignored", 32'(cpu_seen), 32'd0);
        $display("[TB] run cycles=%0d pc=%0h", cnt, pc);

        // Full dump with a stalling sink
        load_pc(32'hA0);
        for (int i = 0; i < 32; i++) begin
            e.addr = 5'(i);
            e.data = 32'hA0 + 32'(i);
            e.last = (i == 31);
            sb.push_back(e);
        end
        send(2'b11);
        cyc = 0;
        held = 1'b0;
        held_data = 32'd0;
        held_addr = 5'd0;
        cpu_seen = 1'b0;
        while (sb.size() > 0 && cyc < 400) begin
            dump_ready = (cyc % 3) != 0;
            if (cpu_en) cpu_seen = 1'b1;
            if (dump_valid) begin
                if (held) begin
                    chk("dump_stable_data", dump_data, held_data);
                    chk("dump_stable_addr", 32'(dump_addr), 32'(held_addr));
                end
                if (dump_ready) begin
                    e = sb.pop_front();
                    chk("dump_addr", 32'(dump_addr), 32'(e.addr));
                    chk("dump_data", dump_data, e.data);
                    chk("dump_last", 32'(dump_last), 32'(e.last));
                    $display("[TB] dump word addr=%0d data=%0h last=%0b", dump_addr, dump_data, dump_last);
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = dump_data;
                    held_addr = dump_addr;
                end
            end else begin
                chk("dump_last_idle", 32'(dump_last), 32'd0);
            end
            tick;
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump_words_remaining", 32'(sb.size()), 32'd0);
        chk("dump_done_halted", 32'(halted), 32'd1);
        chk("dump_done_valid", 32'(dump_valid), 32'd0);
        chk("dump_cpu_idle", 32'(cpu_seen), 32'd0);
        chk("dump_min_cycles", 32'(cyc >= 64), 32'd1);

        // Reset in the middle of a dump
        load_pc(32'hA0);
        send(2'b11);
        dump_ready = 1'b1;
        words = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (dump_valid && dump_addr == 5'd7) found = 1'b1;
            else begin
                if (dump_valid) words++;
                tick;
            end
        end
        rst = 1'b1;
        dump_ready = 1'b0;
        tick;
        chk("abort_found_idx7", 32'(found), 32'd1);
        chk("abort_words_before", 32'(words), 32'd7);
        chk("abort_dump_valid", 32'(dump_valid), 32'd0);
        chk("abort_halted", 32'(halted), 32'd1);
        chk("abort_dump_addr", 32'(dump_addr), 32'd0);
        chk("abort_dump_data", dump_data, 32'd0);
        rst = 1'b0;
        dump_ready = 1'b1;
        extra = 0;
        repeat (80) begin
            if (dump_valid) extra++;
            tick;
        end
        chk("abort_no_more_words", 32'(extra), 32'd0);
        chk("abort_still_halted", 32'(halted), 32'd1);
        $display("[TB] dump abort after %0d words", words);

        // Breakpoint at pc=5
        dump_ready = 1'b0;
        load_pc(32'd0);
        bp_en = 1'b1;
        bp_addr = 32'd5;
        send(2'b00);
        cnt = 0;
        while (pc != 32'd5 && cnt < 20) begin
            tick;
            cnt++;
        end
        chk("bp_reach_pc5", pc, 32'd5);
`ifdef SM_DBG_BREAKPOINT_EN
        chk("bp_cpu_en_drop", 32'(cpu_en), 32'd0);
        tick;
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_hit_set", 32'(bp_hit), 32'd1);
        chk("bp_pc_held", pc, 32'd5);
        send(2'b00);
        chk("bp_resume_cpu_en", 32'(cpu_en), 32'd1);
        chk("bp_resume_pc", pc, 32'd5);
        chk("bp_hit_cleared", 32'(bp_hit), 32'd0);
        tick;
        chk("bp_resume_pc_next", pc, 32'd6);
        chk("bp_resume_running", 32'(halted), 32'd0);
`else
        chk("nobp_cpu_en", 32'(cpu_en), 32'd1);
        chk("nobp_bp_hit", 32'(bp_hit), 32'd0);
        tick;
        chk("nobp_pc_next", pc, 32'd6);
        chk("nobp_running", 32'(halted), 32'd0);
`endif
        send(2'b01);
        chk("bp_final_halted", 32'(halted), 32'd1);
        $display("[TB] breakpoint phase pc=%0h bp_hit=%0b", pc, bp_hit);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
